freq_period_meter: RTL and testbench

Measures the period and high time of a slow square wave, counting in cycles of the system clock. The square wave is typically a divided clock or a tick from elsewhere in the design. It synchronises the asynchronous input, detects edges, and counts system-clock cycles between consecutive rising edges and from each rising edge to the following falling edge. Each completed period produces a coherent (period, high-time) pair with a one-cycle valid strobe. The block is the checking end of the clock-divider chain and is used to verify divider outputs on hardware.

---
 rtl/freq_period_meter_if.sv | 22 ++
 rtl/freq_period_meter.sv | 121 ++++++++++++
 tb/tb_freq_period_meter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/freq_period_meter_if.sv
// Signal bundle between a measured square-wave source and freq_period_meter.
// The meter takes the slave side; whoever drives i_sig takes the master side.
interface freq_period_meter_if #(
    parameter int unsigned CNT_W = 28
);
    logic             i_sig;
    logic [CNT_W-1:0] o_period;
    logic [CNT_W-1:0] o_high;
    logic             o_valid;
    logic             o_locked;
    logic             o_timeout;

    modport master (
        output i_sig,
        input  o_period, o_high, o_valid, o_locked, o_timeout
    );

    modport slave (
        input  i_sig,
        output o_period, o_high, o_valid, o_locked, o_timeout
    );
endinterface

// File: rtl/freq_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// reporting a coherent (period, high) pair with a one-cycle valid strobe.
module freq_period_meter #(
    parameter int unsigned      CNT_W   = 28,
    parameter logic [CNT_W-1:0] TIMEOUT = 28'd200000000
) (
    input  logic              clk,
    input  logic              rst,
    freq_period_meter_if.slave bus
);
    typedef enum logic {
        IDLE,
        MEASURE
    } state_e;

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TERM = TIMEOUT - ONE;

    logic s1, s2, s3;
    logic rise, fall;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] high_lat_q, high_lat_d;
    logic [CNT_W-1:0] period_q,   period_d;
    logic [CNT_W-1:0] high_q,     high_d;
    logic             valid_q,    valid_d;
    logic             locked_q,   locked_d;
    logic             timeout_q,  timeout_d;

    // s1/s2 resolve metastability; s3 is history for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.i_sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_lat_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_lat_q <= high_lat_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
        end
    end

    // NOTE: every output of this block gets a hold/default value first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_lat_d = high_lat_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        timeout_d  = timeout_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end
            end

            MEASURE: begin
                cnt_d = cnt_q + ONE;
                if (fall) begin
                    high_lat_d = cnt_q + ONE;
                end
                // A rise on the terminal count still closes a valid period.
                if (rise) begin
                    period_d = cnt_q + ONE;
                    high_d   = high_lat_q;
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q == TERM) begin
                    state_d   = IDLE;
                    locked_d  = 1'b0;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.o_period  = period_q;
    assign bus.o_high    = high_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_locked  = locked_q;
    assign bus.o_timeout = timeout_q;
endmodule

// File: tb/tb_freq_period_meter.sv
// Directed bench for freq_period_meter: stimulus pushes expected pairs into a
// queue, an independent monitor pops and compares on every o_valid.
module tb_freq_period_meter;
    localparam int unsigned      CNT_W   = 16;
    localparam logic [CNT_W-1:0] TIMEOUT = 16'd100;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    freq_period_meter_if #(.CNT_W(CNT_W)) dif ();

    freq_period_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif.slave)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    pair_t exp_q[$];
    bit    armed    = 1'b0;
    int    pend_p   = 0;
    int    pend_h   = 0;
    logic  prev_valid = 1'b0;
    pair_t mon_e;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (dif.o_valid) begin
                check("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got o_valid with period=%0d high=%0d, required no o_valid",
                             dif.o_period, dif.o_high);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("period", 32'(dif.o_period), 32'(mon_e.period));
                    check("high", 32'(dif.o_high), 32'(mon_e.high));
                    check("locked_with_valid", {31'd0, dif.o_locked}, 32'd1);
                end
            end
            prev_valid = dif.o_valid;
        end
    end

    task automatic drive(input logic v, input int n);
        dif.i_sig = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Opening a new period closes the previous one, which the DUT then reports.
    task automatic close_pending(input int h, input int l);
        pair_t e;
        if (armed) begin
            e.period = CNT_W'(pend_p);
            e.high   = CNT_W'(pend_h);
            exp_q.push_back(e);
        end
        armed  = 1'b1;
        pend_p = h + l;
        pend_h = h;
    endtask

    task automatic period(input int h, input int l);
        close_pending(h, l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"},  32'(dif.o_period), 32'd0);
        check({tag, "_high"},    32'(dif.o_high), 32'd0);
        check({tag, "_valid"},   {31'd0, dif.o_valid}, 32'd0);
        check({tag, "_locked"},  {31'd0, dif.o_locked}, 32'd0);
        check({tag, "_timeout"}, {31'd0, dif.o_timeout}, 32'd0);
    endtask

    initial begin
        int edges;
        int t_cnt;

        dif.i_sig = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        drive(1'b0, 3);

        // Symmetric 5/5: first rise silent, then 10/5 each period.
        for (int i = 0; i < 4; i++) period(5, 5);
        check("sym_locked", {31'd0, dif.o_locked}, 32'd1);

        // Asymmetric 7/3, then switch to 2/2.
        for (int i = 0; i < 4; i++) period(7, 3);
        for (int i = 0; i < 5; i++) period(2, 2);

        // Minimum period: toggle every clock.
        for (int i = 0; i < 8; i++) period(1, 1);

        // Timeout: 8/8 wave, then a final rise followed by a long low.
        for (int i = 0; i < 3; i++) period(8, 8);
        close_pending(8, 8);
        dif.i_sig = 1'b1;
        edges = 0;
        t_cnt = -1;
        while (!dif.o_timeout && edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 8) dif.i_sig = 1'b0;
            if (dif.o_valid) t_cnt = 0;
            else if (t_cnt >= 0) t_cnt++;
        end
        armed = 1'b0;
        check("timeout_flag", {31'd0, dif.o_timeout}, 32'd1);
        check("timeout_latency", 32'(t_cnt), 32'd100);
        check("timeout_unlocked", {31'd0, dif.o_locked}, 32'd0);
        check("timeout_period_held", 32'(dif.o_period), 32'd16);
        check("timeout_high_held", 32'(dif.o_high), 32'd8);
        drive(1'b0, 5);
        check("timeout_sticky", {31'd0, dif.o_timeout}, 32'd1);

        // Resume: first rise clears the flag without reporting.
        period(8, 8);
        check("timeout_cleared", {31'd0, dif.o_timeout}, 32'd0);
        check("relock_pending", {31'd0, dif.o_locked}, 32'd0);
        period(8, 8);
        check("relocked", {31'd0, dif.o_locked}, 32'd1);

        // Period equal to TIMEOUT: rise on the terminal count wins.
        for (int i = 0; i < 4; i++) period(80, 20);
        check("terminal_no_timeout", {31'd0, dif.o_timeout}, 32'd0);
        check("terminal_locked", {31'd0, dif.o_locked}, 32'd1);

        // Reset on the last high cycle of a 6/4 wave.
        period(6, 4);
        period(6, 4);
        close_pending(6, 4);
        drive(1'b1, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        rst = 1'b0;
        armed = 1'b0;
        drive(1'b0, 4);
        for (int i = 0; i < 3; i++) period(6, 4);

        drive(1'b0, 10);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
